// File: rtl/imm_decode_pipe.sv
// imm_decode_pipe: registered RISC-V immediate decoder with a 2-entry skid buffer.
// The format is derived from the opcode. The immediate is sign-extended to XLEN.
// XLEN may be 32 or 64. With XLEN==64, the OP-IMM-32 and OP-32 opcodes are recognised.
// Optional feature macro: IMM_DECODE_ZICSR_EN.
//   When defined, csrrwi/csrrsi/csrrci decode as format Z.
//   The Z immediate is the zero-extended rs1 field.
module imm_decode_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt
);

  localparam logic [2:0] FMT_I    = 3'b000;
  localparam logic [2:0] FMT_S    = 3'b001;
  localparam logic [2:0] FMT_B    = 3'b010;
  localparam logic [2:0] FMT_U    = 3'b011;
  localparam logic [2:0] FMT_J    = 3'b100;
  localparam logic [2:0] FMT_Z    = 3'b101;
  localparam logic [2:0] FMT_NONE = 3'b110;
  localparam logic [2:0] FMT_UNK  = 3'b111;

  logic [2:0]      dec_fmt;
  logic [31:0]     dec_imm32;
  logic [XLEN-1:0] dec_imm;

  logic            main_valid_q, main_valid_d;
  logic [XLEN-1:0] main_imm_q,   main_imm_d;
  logic [2:0]      main_fmt_q,   main_fmt_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_imm_q,   skid_imm_d;
  logic [2:0]      skid_fmt_q,   skid_fmt_d;

  logic drain;
  logic in_xfer;

  // Opcode to format classification.
  always_comb begin
    dec_fmt = FMT_UNK;
    case (in_instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111: dec_fmt = FMT_I;
      7'b1110011: begin
        dec_fmt = FMT_I;
`ifdef IMM_DECODE_ZICSR_EN
        if (in_instr[14]) dec_fmt = FMT_Z;
`else
`endif
      end
      7'b0100011: dec_fmt = FMT_S;
      7'b1100011: dec_fmt = FMT_B;
      7'b0110111, 7'b0010111: dec_fmt = FMT_U;
      7'b1101111: dec_fmt = FMT_J;
      7'b0110011: dec_fmt = FMT_NONE;
      7'b0011011: if (XLEN == 64) dec_fmt = FMT_I;
      7'b0111011: if (XLEN == 64) dec_fmt = FMT_NONE;
      default:    dec_fmt = FMT_UNK;
    endcase
  end

  // Immediate assembly per format, then sign extension from bit 31 to XLEN.
  always_comb begin
    dec_imm32 = 32'd0;
    case (dec_fmt)
      FMT_I: dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S: dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B: dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                          in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_U: dec_imm32 = {in_instr[31:12], 12'd0};
      FMT_J: dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                          in_instr[20], in_instr[30:21], 1'b0};
      FMT_Z: dec_imm32 = {27'd0, in_instr[19:15]};
      default: dec_imm32 = 32'd0;
    endcase
    dec_imm       = {XLEN{dec_imm32[31]}};
    dec_imm[31:0] = dec_imm32;
  end

  assign in_ready  = !skid_valid_q;
  assign drain     = main_valid_q && out_ready;
  assign in_xfer   = in_valid && in_ready;
  assign out_valid = main_valid_q;
  assign out_imm   = main_imm_q;
  assign out_fmt   = main_fmt_q;

  // Next-state for the main/skid pair.
  // Main refills from skid first to keep FIFO order.
  always_comb begin
    main_valid_d = main_valid_q;
    main_imm_d   = main_imm_q;
    main_fmt_d   = main_fmt_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_fmt_d   = skid_fmt_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || drain) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_imm_d   = skid_imm_q;
        main_fmt_d   = skid_fmt_q;
        skid_valid_d = 1'b0;
      end else if (in_xfer) begin
        main_valid_d = 1'b1;
        main_imm_d   = dec_imm;
        main_fmt_d   = dec_fmt;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = dec_imm;
      skid_fmt_d   = dec_fmt;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_imm_q   <= '0;
      main_fmt_q   <= FMT_I;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_fmt_q   <= FMT_I;
    end else begin
      main_valid_q <= main_valid_d;
      main_imm_q   <= main_imm_d;
      main_fmt_q   <= main_fmt_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_fmt_q   <= skid_fmt_d;
    end
  end

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Bench for imm_decode_pipe.
// Two instances, XLEN=32 and XLEN=64, run in lockstep on one input stream.
// A scoreboard queue per instance holds the expected outputs in order.
module tb_imm_decode_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = 32'd0;
  logic        out_ready = 1'b0;

  logic        in_ready32, out_valid32;
  logic [31:0] out_imm32;
  logic [2:0]  out_fmt32;
  logic        in_ready64, out_valid64;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt64;

  always #5 clk = ~clk;

  imm_decode_pipe #(.XLEN(32)) u32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_fmt(out_fmt32));

  imm_decode_pipe #(.XLEN(64)) u64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_fmt(out_fmt64));

  typedef struct {
    logic [31:0] ins;
    logic [2:0]  f32;
    logic [63:0] i32;
    logic [2:0]  f64;
    logic [63:0] i64;
  } vec_t;

  typedef struct {
    logic [2:0]  f;
    logic [63:0] i;
  } exp_t;

  vec_t vt[12];
  exp_t q32[$];
  exp_t q64[$];
  vec_t cur;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: pop on output transfer, push on input transfer; flush/reset empty it.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q32.delete();
      q64.delete();
    end else if (flush) begin
      q32.delete();
      q64.delete();
    end else begin
      if (out_valid32 && out_ready) begin
        if (q32.size() == 0) chk("extra_out32", {63'd0, out_valid32}, 64'd0);
        else begin
          e = q32.pop_front();
          chk("fmt32", {61'd0, out_fmt32}, {61'd0, e.f});
          chk("imm32", {32'd0, out_imm32}, e.i);
        end
      end
      if (out_valid64 && out_ready) begin
        if (q64.size() == 0) chk("extra_out64", {63'd0, out_valid64}, 64'd0);
        else begin
          e = q64.pop_front();
          chk("fmt64", {61'd0, out_fmt64}, {61'd0, e.f});
          chk("imm64", out_imm64, e.i);
        end
      end
      if (in_valid && in_ready32) begin
        e.f = cur.f32; e.i = {32'd0, cur.i32[31:0]};
        q32.push_back(e);
      end
      if (in_valid && in_ready64) begin
        e.f = cur.f64; e.i = cur.i64;
        q64.push_back(e);
      end
    end
  end

  // Offer one instruction and hold it until accepted; tput demands zero stall cycles.
  task automatic send(input vec_t v, input bit tput);
    int waited;
    waited = 0;
    cur = v;
    in_instr = v.ins;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready32 && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 50) chk("accept_timeout", {63'd0, in_ready32}, 64'd1);
    if (tput) chk("tput_stall", 64'(waited), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    vt[0]  = '{32'hFFF00093, 3'd0, 64'hFFFFFFFF, 3'd0, 64'hFFFFFFFFFFFFFFFF};
    vt[1]  = '{32'h00112623, 3'd1, 64'h0000000C, 3'd1, 64'h000000000000000C};
    vt[2]  = '{32'hFE000EE3, 3'd2, 64'hFFFFFFFC, 3'd2, 64'hFFFFFFFFFFFFFFFC};
    vt[3]  = '{32'h123450B7, 3'd3, 64'h12345000, 3'd3, 64'h0000000012345000};
    vt[4]  = '{32'h800000B7, 3'd3, 64'h80000000, 3'd3, 64'hFFFFFFFF80000000};
    vt[5]  = '{32'h0000003B, 3'd7, 64'h0,        3'd6, 64'h0};
    vt[6]  = '{32'h00000033, 3'd6, 64'h0,        3'd6, 64'h0};
`ifdef IMM_DECODE_ZICSR_EN
    vt[7]  = '{32'h300FD073, 3'd5, 64'h1F,       3'd5, 64'h1F};
`else
    vt[7]  = '{32'h300FD073, 3'd0, 64'h300,      3'd0, 64'h300};
`endif
    vt[8]  = '{32'hFFDFF06F, 3'd4, 64'hFFFFFFFC, 3'd4, 64'hFFFFFFFFFFFFFFFC};
    vt[9]  = '{32'hFFF0001B, 3'd7, 64'h0,        3'd0, 64'hFFFFFFFFFFFFFFFF};
    vt[10] = '{32'h00412083, 3'd0, 64'h4,        3'd0, 64'h4};
    vt[11] = '{32'h00000000, 3'd7, 64'h0,        3'd7, 64'h0};

    // Reset values, checked while reset is held.
    #12;
    chk("rst_oval32", {63'd0, out_valid32}, 64'd0);
    chk("rst_imm32",  {32'd0, out_imm32},   64'd0);
    chk("rst_fmt32",  {61'd0, out_fmt32},   64'd0);
    chk("rst_rdy32",  {63'd0, in_ready32},  64'd1);
    chk("rst_oval64", {63'd0, out_valid64}, 64'd0);
    chk("rst_imm64",  out_imm64,            64'd0);
    chk("rst_rdy64",  {63'd0, in_ready64},  64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // Streaming with out_ready high: every vector accepted without a stall.
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) send(vt[k], 1'b1);
    @(negedge clk);
    chk("last_latency", {63'd0, out_valid32}, 64'd1);
    idle(3);

    // Backpressure: A and B fill main and skid, C must wait.
    out_ready = 1'b0;
    send(vt[0], 1'b1);
    send(vt[1], 1'b1);
    cur = vt[3];
    in_instr = vt[3].ins;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_rdy32",  {63'd0, in_ready32},  64'd0);
      chk("bp_rdy64",  {63'd0, in_ready64},  64'd0);
      chk("bp_oval",   {63'd0, out_valid32}, 64'd1);
      chk("bp_hold_imm", {32'd0, out_imm32}, vt[0].i32);
      chk("bp_hold_fmt", {61'd0, out_fmt32}, {61'd0, vt[0].f32});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(vt[3], 1'b0);
    idle(4);

    // Flush with main and skid full, input offered in the same cycle.
    out_ready = 1'b0;
    send(vt[2], 1'b1);
    send(vt[4], 1'b1);
    cur = vt[8];
    in_instr = vt[8].ins;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("fl_oval32", {63'd0, out_valid32}, 64'd0);
    chk("fl_rdy32",  {63'd0, in_ready32},  64'd1);
    chk("fl_oval64", {63'd0, out_valid64}, 64'd0);

    // Flush while in_ready is high: the same-cycle input must be dropped.
    send(vt[10], 1'b1);
    cur = vt[9];
    in_instr = vt[9].ins;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("fl2_oval32", {63'd0, out_valid32}, 64'd0);
    chk("fl2_rdy32",  {63'd0, in_ready32},  64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(vt[6], 1'b1);
    idle(3);

    // Asynchronous reset with two instructions held.
    out_ready = 1'b0;
    send(vt[0], 1'b1);
    send(vt[1], 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_oval32", {63'd0, out_valid32}, 64'd0);
    chk("ar_rdy32",  {63'd0, in_ready32},  64'd1);
    chk("ar_imm64",  out_imm64,            64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(vt[7], 1'b1);
    send(vt[5], 1'b1);

    for (int k = 0; k < 20 && (q32.size() != 0 || q64.size() != 0); k++) @(posedge clk);
    @(negedge clk);
    chk("drain32", 64'(q32.size()), 64'd0);
    chk("drain64", 64'(q64.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
